// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the branch resolve unit: conditional-branch funct3
// encodings, the prediction-flag layout stored with each in-flight fetch,
// and the branch condition evaluator.
package branch_resolve_unit_pkg;

    // RISC-V conditional branch encodings; 010 and 011 are unused.
    typedef enum logic [2:0] {
        F3_BEQ  = 3'b000,
        F3_BNE  = 3'b001,
        F3_BLT  = 3'b100,
        F3_BGE  = 3'b101,
        F3_BLTU = 3'b110,
        F3_BGEU = 3'b111
    } branch_funct3_e;

    // Low bits of a FIFO entry. A full entry is laid out as
    // {pc, target, predicted, predict1, predict3, is_loop}.
    typedef struct packed {
        logic predicted;
        logic predict1;
        logic predict3;
        logic is_loop;
    } pred_flags_t;

    localparam int FLAG_BITS = $bits(pred_flags_t);

    // Outcome of a conditional branch from precomputed operand comparisons.
    function automatic logic branch_taken(input logic [2:0] funct3,
                                          input logic       eq,
                                          input logic       lt_s,
                                          input logic       lt_u);
        logic t;
        t = 1'b0;
        case (funct3)
            F3_BEQ:  t = eq;
            F3_BNE:  t = !eq;
            F3_BLT:  t = lt_s;
            F3_BGE:  t = !lt_s;
            F3_BLTU: t = lt_u;
            F3_BGEU: t = !lt_u;
            default: t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/branch_meta_fifo.sv
// Synchronous FIFO holding prediction metadata for instructions between
// fetch and EX. Pointers carry an extra wrap bit so full and empty are
// distinguishable without a separate count. A flush discards every entry
// still queued after this cycle's pop, and refuses this cycle's push.
module branch_meta_fifo #(
    parameter int WIDTH = 68,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int            PTR_W   = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = (PTR_W + 1)'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic             do_push, do_pop;

    assign empty_o = (rd_ptr_q == wr_ptr_q);
    assign full_o  = (rd_ptr_q[PTR_W] != wr_ptr_q[PTR_W]) &&
                     (rd_ptr_q[PTR_W-1:0] == wr_ptr_q[PTR_W-1:0]);
    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q[PTR_W-1:0]];

    // Next pointer values: flush jumps read to write, which also covers the pop.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // through the block leaves it unassigned and a latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (flush_i) begin
            rd_ptr_d = wr_ptr_q;
        end else if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    // Entry storage, written on an accepted push.
    // NOTE: the storage array is deliberately not reset; an entry is only
    // observed through head_o while the pointers say it is valid.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= data_i;
        end
    end

    // Pointer registers; reset empties the FIFO.
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block order.
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves conditional branches and JALR in EX against the prediction that
// fetch made for the same PC, raises a registered mispredict/redirect, and
// feeds the outcome back to the predictor one cycle after EX. Also keeps
// saturating counts of resolved control instructions and mispredictions.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  cpu_clk,
    input  logic                  cpu_rst,
    // fetch side
    input  logic                  fetch_valid,
    output logic                  fetch_ready,
    input  logic [ADDR_WIDTH-1:0] fetch_pc,
    input  logic                  predict_taken,
    input  logic                  predict1_taken,
    input  logic                  predict3_taken,
    input  logic                  is_loop,
    input  logic [ADDR_WIDTH-1:0] predict_target_pc,
    // EX side
    input  logic                  ex_valid,
    input  logic [ADDR_WIDTH-1:0] ex_pc,
    input  logic                  ex_is_branch,
    input  logic                  ex_is_jalr,
    input  logic [2:0]            ex_funct3,
    input  logic [DATA_WIDTH-1:0] ex_imm,
    input  logic [DATA_WIDTH-1:0] src_data1,
    input  logic [DATA_WIDTH-1:0] src_data2,
    // predictor update
    output logic                  branch_ex,
    output logic                  jalr_ex,
    output logic [ADDR_WIDTH-1:0] branch_pc_ex,
    output logic [ADDR_WIDTH-1:0] branch_target_pc,
    output logic                  branch_taken_ex,
    output logic                  predict1_taken_ex,
    output logic                  predict3_taken_ex,
    output logic                  is_loop_ex,
    output logic [DATA_WIDTH-1:0] src_data1_ex,
    output logic [DATA_WIDTH-1:0] src_data2_ex,
    // redirect
    output logic                  mispredict,
    output logic [ADDR_WIDTH-1:0] redirect_pc,
    // statistics
    output logic [CNT_WIDTH-1:0]  branch_cnt,
    output logic [CNT_WIDTH-1:0]  mispredict_cnt
);

    localparam int                    ENTRY_W = 2 * ADDR_WIDTH + FLAG_BITS;
    localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] PC_LSB  = ADDR_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE = CNT_WIDTH'(1);

    // prediction metadata path
    logic [ENTRY_W-1:0]    push_entry, head_entry;
    logic                  fifo_full, fifo_empty;
    logic [ADDR_WIDTH-1:0] head_pc, head_target;
    pred_flags_t           head_flags, pred;
    logic                  head_match;

    // resolution path
    logic [ADDR_WIDTH-1:0] imm_ext, br_target, jalr_target, pc_plus4;
    logic [DATA_WIDTH-1:0] jalr_sum;
    logic                  op_eq, op_lt_s, op_lt_u;
    logic                  is_ctrl, taken, mispredict_d;
    logic [ADDR_WIDTH-1:0] target, redirect_d;

    // registered outputs
    logic                  branch_ex_q, jalr_ex_q, branch_taken_q;
    logic                  predict1_q, predict3_q, is_loop_q, mispredict_q;
    logic [ADDR_WIDTH-1:0] branch_pc_q, branch_target_q, redirect_pc_q;
    logic [DATA_WIDTH-1:0] src1_q, src2_q;
    logic [CNT_WIDTH-1:0]  branch_cnt_q, branch_cnt_d;
    logic [CNT_WIDTH-1:0]  mispredict_cnt_q, mispredict_cnt_d;

    // Ready depends only on registered pointers, so a pop in EX never
    // reaches fetch_ready combinationally.
    assign fetch_ready = !fifo_full;
    assign push_entry  = {fetch_pc, predict_target_pc,
                          predict_taken, predict1_taken, predict3_taken, is_loop};

    // The cycle a mispredict is visible, every younger entry is wrong-path.
    branch_meta_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_meta_fifo (
        .clk_i   (cpu_clk),
        .rst_i   (cpu_rst),
        .push_i  (fetch_valid && fetch_ready),
        .data_i  (push_entry),
        .pop_i   (ex_valid),
        .flush_i (mispredict_q),
        .head_o  (head_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign head_pc     = head_entry[ENTRY_W-1 -: ADDR_WIDTH];
    assign head_target = head_entry[FLAG_BITS +: ADDR_WIDTH];
    assign head_flags  = pred_flags_t'(head_entry[FLAG_BITS-1:0]);

    // A stale or missing entry means fetch predicted "not taken, no flags".
    assign head_match = !fifo_empty && (head_pc == ex_pc);
    assign pred       = head_match ? head_flags : '0;

    assign op_eq   = (src_data1 == src_data2);
    assign op_lt_s = ($signed(src_data1) < $signed(src_data2));
    assign op_lt_u = (src_data1 < src_data2);

    assign imm_ext     = ADDR_WIDTH'($signed(ex_imm));
    assign br_target   = ex_pc + imm_ext;
    assign jalr_sum    = src_data1 + ex_imm;
    assign jalr_target = ADDR_WIDTH'(jalr_sum) & ~PC_LSB;
    assign pc_plus4    = ex_pc + PC_STEP;

    // Actual outcome, target and mispredict decision for the EX instruction.
    always_comb begin
        is_ctrl      = ex_valid && (ex_is_branch || ex_is_jalr);
        taken        = 1'b0;
        target       = br_target;
        mispredict_d = 1'b0;
        if (ex_is_jalr) begin
            taken  = 1'b1;
            target = jalr_target;
        end else if (ex_is_branch) begin
            taken = branch_taken(ex_funct3, op_eq, op_lt_s, op_lt_u);
        end
        if (is_ctrl) begin
            mispredict_d = (pred.predicted != taken) ||
                           (taken && (head_target != target));
        end else if (ex_valid) begin
            // BTB alias: fetch redirected on something that is not a branch.
            mispredict_d = pred.predicted;
        end
        redirect_d = taken ? target : pc_plus4;
    end

    // Saturating statistics, advanced in step with the registered strobes.
    always_comb begin
        branch_cnt_d     = branch_cnt_q;
        mispredict_cnt_d = mispredict_cnt_q;
        if (is_ctrl && (branch_cnt_q != '1)) begin
            branch_cnt_d = branch_cnt_q + CNT_ONE;
        end
        if (mispredict_d && (mispredict_cnt_q != '1)) begin
            mispredict_cnt_d = mispredict_cnt_q + CNT_ONE;
        end
    end

    // Register predictor update, redirect and counters one cycle after EX.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            branch_ex_q      <= 1'b0;
            jalr_ex_q        <= 1'b0;
            branch_pc_q      <= '0;
            branch_target_q  <= '0;
            branch_taken_q   <= 1'b0;
            predict1_q       <= 1'b0;
            predict3_q       <= 1'b0;
            is_loop_q        <= 1'b0;
            src1_q           <= '0;
            src2_q           <= '0;
            mispredict_q     <= 1'b0;
            redirect_pc_q    <= '0;
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            branch_ex_q      <= is_ctrl;
            mispredict_q     <= mispredict_d;
            branch_cnt_q     <= branch_cnt_d;
            mispredict_cnt_q <= mispredict_cnt_d;
            if (is_ctrl) begin
                jalr_ex_q       <= ex_is_jalr;
                branch_pc_q     <= ex_pc;
                branch_target_q <= target;
                branch_taken_q  <= taken;
                predict1_q      <= pred.predict1;
                predict3_q      <= pred.predict3;
                is_loop_q       <= pred.is_loop;
                src1_q          <= src_data1;
                src2_q          <= src_data2;
            end
            if (mispredict_d) begin
                redirect_pc_q <= redirect_d;
            end
        end
    end

    assign branch_ex         = branch_ex_q;
    assign jalr_ex           = jalr_ex_q;
    assign branch_pc_ex      = branch_pc_q;
    assign branch_target_pc  = branch_target_q;
    assign branch_taken_ex   = branch_taken_q;
    assign predict1_taken_ex = predict1_q;
    assign predict3_taken_ex = predict3_q;
    assign is_loop_ex        = is_loop_q;
    assign src_data1_ex      = src1_q;
    assign src_data2_ex      = src2_q;
    assign mispredict        = mispredict_q;
    assign redirect_pc       = redirect_pc_q;
    assign branch_cnt        = branch_cnt_q;
    assign mispredict_cnt    = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: each cycle's stimulus is run
// through a reference model; expected update/redirect results are queued at
// the clock edge and compared by a monitor when the DUT presents them.
module tb_branch_resolve_unit;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        pred;
        logic        p1;
        logic        p3;
        logic        loop;
    } meta_t;

    typedef struct packed {
        logic        valid;
        logic        isb;
        logic        isj;
        logic [2:0]  f3;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] s1;
        logic [31:0] s2;
    } ex_t;

    typedef struct packed {
        logic        br;
        logic        mis;
        logic        jalr;
        logic [31:0] pc;
        logic [31:0] target;
        logic        taken;
        logic        p1;
        logic        p3;
        logic        loop;
        logic [31:0] s1;
        logic [31:0] s2;
        logic [31:0] redirect;
    } exp_t;

    logic        cpu_clk, cpu_rst;
    logic        fetch_valid, fetch_ready;
    logic [31:0] fetch_pc, predict_target_pc;
    logic        predict_taken, predict1_taken, predict3_taken, is_loop;
    logic        ex_valid, ex_is_branch, ex_is_jalr;
    logic [31:0] ex_pc, ex_imm, src_data1, src_data2;
    logic [2:0]  ex_funct3;
    logic        branch_ex, jalr_ex, branch_taken_ex;
    logic        predict1_taken_ex, predict3_taken_ex, is_loop_ex, mispredict;
    logic [31:0] branch_pc_ex, branch_target_pc, src_data1_ex, src_data2_ex;
    logic [31:0] redirect_pc, branch_cnt, mispredict_cnt;

    meta_t       mq[$];
    exp_t        exp_q[$];
    exp_t        mon_e;
    bit          flush_pending;
    logic [31:0] m_bcnt, m_mcnt;
    int          n_cmp, n_err;

    localparam meta_t NO_META = '0;
    localparam ex_t   NO_EX   = '0;

    branch_resolve_unit dut (
        .cpu_clk           (cpu_clk),
        .cpu_rst           (cpu_rst),
        .fetch_valid       (fetch_valid),
        .fetch_ready       (fetch_ready),
        .fetch_pc          (fetch_pc),
        .predict_taken     (predict_taken),
        .predict1_taken    (predict1_taken),
        .predict3_taken    (predict3_taken),
        .is_loop           (is_loop),
        .predict_target_pc (predict_target_pc),
        .ex_valid          (ex_valid),
        .ex_pc             (ex_pc),
        .ex_is_branch      (ex_is_branch),
        .ex_is_jalr        (ex_is_jalr),
        .ex_funct3         (ex_funct3),
        .ex_imm            (ex_imm),
        .src_data1         (src_data1),
        .src_data2         (src_data2),
        .branch_ex         (branch_ex),
        .jalr_ex           (jalr_ex),
        .branch_pc_ex      (branch_pc_ex),
        .branch_target_pc  (branch_target_pc),
        .branch_taken_ex   (branch_taken_ex),
        .predict1_taken_ex (predict1_taken_ex),
        .predict3_taken_ex (predict3_taken_ex),
        .is_loop_ex        (is_loop_ex),
        .src_data1_ex      (src_data1_ex),
        .src_data2_ex      (src_data2_ex),
        .mispredict        (mispredict),
        .redirect_pc       (redirect_pc),
        .branch_cnt        (branch_cnt),
        .mispredict_cnt    (mispredict_cnt)
    );

    initial begin
        cpu_clk = 1'b0;
        forever #5 cpu_clk = ~cpu_clk;
    end

    function automatic meta_t mk_meta(input logic [31:0] pc, input logic pred,
                                      input logic [31:0] tgt);
        meta_t m;
        m.pc = pc; m.tgt = tgt; m.pred = pred;
        m.p1 = pred; m.p3 = ~pred; m.loop = pc[2];
        return m;
    endfunction

    function automatic ex_t mk_br(input logic [31:0] pc, input logic [2:0] f3,
                                  input logic [31:0] imm, input logic [31:0] s1,
                                  input logic [31:0] s2);
        ex_t x;
        x = '0;
        x.valid = 1'b1; x.isb = 1'b1; x.f3 = f3;
        x.pc = pc; x.imm = imm; x.s1 = s1; x.s2 = s2;
        return x;
    endfunction

    function automatic ex_t mk_jalr(input logic [31:0] pc, input logic [31:0] imm,
                                    input logic [31:0] s1);
        ex_t x;
        x = '0;
        x.valid = 1'b1; x.isj = 1'b1; x.pc = pc; x.imm = imm; x.s1 = s1;
        return x;
    endfunction

    function automatic ex_t mk_alu(input logic [31:0] pc);
        ex_t x;
        x = '0;
        x.valid = 1'b1; x.pc = pc;
        return x;
    endfunction

    // One clock of stimulus plus the reference model update at its edge.
    task automatic step(input bit fv, input meta_t f, input ex_t x);
        meta_t       head;
        meta_t       dummy;
        exp_t        e;
        bit          push_ok, pop_ok, taken, br, mis;
        logic [31:0] tgt;
        fetch_valid = fv;     fetch_pc = f.pc;        predict_target_pc = f.tgt;
        predict_taken = f.pred; predict1_taken = f.p1; predict3_taken = f.p3;
        is_loop = f.loop;
        ex_valid = x.valid;   ex_pc = x.pc;   ex_is_branch = x.isb;
        ex_is_jalr = x.isj;   ex_funct3 = x.f3; ex_imm = x.imm;
        src_data1 = x.s1;     src_data2 = x.s2;
        push_ok = fv && (mq.size() < DEPTH) && !flush_pending;
        pop_ok  = x.valid && (mq.size() > 0);
        head = '0;
        if (pop_ok && mq[0].pc == x.pc) head = mq[0];
        taken = 1'b0;
        tgt   = x.pc + x.imm;
        if (x.isj) begin
            taken = 1'b1;
            tgt   = (x.s1 + x.imm) & ~32'd1;
        end else if (x.isb) begin
            case (x.f3)
                3'd0: taken = (x.s1 == x.s2);
                3'd1: taken = (x.s1 != x.s2);
                3'd4: taken = ($signed(x.s1) < $signed(x.s2));
                3'd5: taken = ($signed(x.s1) >= $signed(x.s2));
                3'd6: taken = (x.s1 < x.s2);
                3'd7: taken = (x.s1 >= x.s2);
                default: taken = 1'b0;
            endcase
        end
        br = x.valid && (x.isb || x.isj);
        if (br) mis = (head.pred != taken) || (taken && head.tgt != tgt);
        else    mis = x.valid && head.pred;
        e.br = br; e.mis = mis; e.jalr = x.isj; e.pc = x.pc; e.target = tgt;
        e.taken = taken; e.p1 = head.p1; e.p3 = head.p3; e.loop = head.loop;
        e.s1 = x.s1; e.s2 = x.s2; e.redirect = taken ? tgt : x.pc + 32'd4;
        @(posedge cpu_clk);
        if (br || mis) exp_q.push_back(e);
        if (br && m_bcnt != '1) m_bcnt++;
        if (mis && m_mcnt != '1) m_mcnt++;
        if (pop_ok) dummy = mq.pop_front();
        if (push_ok) mq.push_back(f);
        if (flush_pending) mq.delete();
        flush_pending = mis;
        #1;
    endtask

    task automatic idle();
        step(1'b0, NO_META, NO_EX);
    endtask

    task automatic push(input meta_t f);
        step(1'b1, f, NO_EX);
    endtask

    task automatic model_reset();
        mq.delete();
        exp_q.delete();
        flush_pending = 1'b0;
        m_bcnt = '0;
        m_mcnt = '0;
    endtask

    // Monitor: results are due the cycle after their EX edge.
    always @(negedge cpu_clk) begin
        if (!cpu_rst) begin
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                n_cmp++;
                if ({branch_ex, mispredict} !== {mon_e.br, mon_e.mis}) begin
                    n_err++;
                    $display("FAIL strobes pc=%h: got br/mis=%b%b expected %b%b",
                             mon_e.pc, branch_ex, mispredict, mon_e.br, mon_e.mis);
                end
                if (mon_e.br) begin
                    n_cmp++;
                    if ({jalr_ex, branch_pc_ex, branch_target_pc, branch_taken_ex,
                         predict1_taken_ex, predict3_taken_ex, is_loop_ex,
                         src_data1_ex, src_data2_ex} !==
                        {mon_e.jalr, mon_e.pc, mon_e.target, mon_e.taken,
                         mon_e.p1, mon_e.p3, mon_e.loop, mon_e.s1, mon_e.s2}) begin
                        n_err++;
                        $display("FAIL update pc=%h: got j=%b pc=%h tgt=%h t=%b p1=%b p3=%b l=%b s=%h/%h expected j=%b pc=%h tgt=%h t=%b p1=%b p3=%b l=%b s=%h/%h",
                                 mon_e.pc, jalr_ex, branch_pc_ex, branch_target_pc,
                                 branch_taken_ex, predict1_taken_ex, predict3_taken_ex,
                                 is_loop_ex, src_data1_ex, src_data2_ex,
                                 mon_e.jalr, mon_e.pc, mon_e.target, mon_e.taken,
                                 mon_e.p1, mon_e.p3, mon_e.loop, mon_e.s1, mon_e.s2);
                    end
                end
                if (mon_e.mis) begin
                    n_cmp++;
                    if (redirect_pc !== mon_e.redirect) begin
                        n_err++;
                        $display("FAIL redirect pc=%h: got %h expected %h",
                                 mon_e.pc, redirect_pc, mon_e.redirect);
                    end
                end
            end else if (branch_ex || mispredict) begin
                n_cmp++;
                n_err++;
                $display("FAIL spurious output: got br/mis=%b%b pc=%h expected none",
                         branch_ex, mispredict, branch_pc_ex);
            end
        end
    end

    task automatic test_reset();
        cpu_rst = 1'b1;
        fetch_valid = 0; fetch_pc = 0; predict_taken = 0; predict1_taken = 0;
        predict3_taken = 0; is_loop = 0; predict_target_pc = 0;
        ex_valid = 0; ex_pc = 0; ex_is_branch = 0; ex_is_jalr = 0;
        ex_funct3 = 0; ex_imm = 0; src_data1 = 0; src_data2 = 0;
        model_reset();
        #12;
        n_cmp++;
        if ({branch_ex, jalr_ex, branch_pc_ex, branch_target_pc, branch_taken_ex,
             predict1_taken_ex, predict3_taken_ex, is_loop_ex, src_data1_ex,
             src_data2_ex, mispredict, redirect_pc, branch_cnt, mispredict_cnt} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got br=%b mis=%b redir=%h cnt=%h/%h expected all zero",
                     branch_ex, mispredict, redirect_pc, branch_cnt, mispredict_cnt);
        end
        n_cmp++;
        if (fetch_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready: got %b expected 1", fetch_ready);
        end
        cpu_rst = 1'b0;
    endtask

    task automatic test_beq_mispredict();
        push(mk_meta(32'h100, 1'b0, 32'h0));
        step(1'b0, NO_META, mk_br(32'h100, 3'd0, 32'h20, 32'd5, 32'd5));
        n_cmp++;
        if ({mispredict, redirect_pc, mispredict_cnt} !== {1'b1, 32'h120, 32'd1}) begin
            n_err++;
            $display("FAIL beq_redirect: got mis=%b redir=%h mcnt=%0d expected 1 120 1",
                     mispredict, redirect_pc, mispredict_cnt);
        end
        idle();
    endtask

    task automatic test_bne_correct();
        push(mk_meta(32'h200, 1'b1, 32'h1F0));
        step(1'b0, NO_META, mk_br(32'h200, 3'd1, 32'hFFFF_FFF0, 32'd1, 32'd2));
        n_cmp++;
        if ({branch_ex, branch_taken_ex, mispredict, branch_cnt} !== {3'b110, m_bcnt}) begin
            n_err++;
            $display("FAIL bne_correct: got br=%b t=%b mis=%b bcnt=%0d expected 1 1 0 %0d",
                     branch_ex, branch_taken_ex, mispredict, branch_cnt, m_bcnt);
        end
        idle();
    endtask

    task automatic test_jalr();
        push(mk_meta(32'h300, 1'b1, 32'h1002));
        step(1'b0, NO_META, mk_jalr(32'h300, 32'h0, 32'h1003));
        n_cmp++;
        if ({mispredict, branch_target_pc, jalr_ex} !== {1'b0, 32'h1002, 1'b1}) begin
            n_err++;
            $display("FAIL jalr_hit: got mis=%b tgt=%h jalr=%b expected 0 1002 1",
                     mispredict, branch_target_pc, jalr_ex);
        end
        push(mk_meta(32'h300, 1'b1, 32'h1000));
        step(1'b0, NO_META, mk_jalr(32'h300, 32'h0, 32'h1003));
        n_cmp++;
        if ({mispredict, redirect_pc} !== {1'b1, 32'h1002}) begin
            n_err++;
            $display("FAIL jalr_target_miss: got mis=%b redir=%h expected 1 1002",
                     mispredict, redirect_pc);
        end
        idle();
    endtask

    task automatic test_fifo_full_flush();
        push(mk_meta(32'h400, 1'b0, 32'h0));
        push(mk_meta(32'h404, 1'b0, 32'h0));
        push(mk_meta(32'h408, 1'b1, 32'h480));
        push(mk_meta(32'h40C, 1'b1, 32'h480));
        n_cmp++;
        if (fetch_ready !== 1'b0) begin
            n_err++;
            $display("FAIL full_ready: got %b expected 0", fetch_ready);
        end
        push(mk_meta(32'h410, 1'b1, 32'h0));
        // pop and a push attempt in the same cycle: push must still be refused
        step(1'b1, mk_meta(32'h414, 1'b1, 32'h0), mk_alu(32'h400));
        n_cmp++;
        if (fetch_ready !== 1'b1) begin
            n_err++;
            $display("FAIL pop_ready: got %b expected 1", fetch_ready);
        end
        step(1'b0, NO_META, mk_br(32'h404, 3'd0, 32'h8, 32'd3, 32'd3));
        idle();
        n_cmp++;
        if ({fetch_ready, mq.size() == 0} !== 2'b11) begin
            n_err++;
            $display("FAIL flush_ready: got %b expected 1", fetch_ready);
        end
        // 0x408 was predicted taken; after the flush it must be unknown
        step(1'b0, NO_META, mk_br(32'h408, 3'd0, 32'h8, 32'd3, 32'd4));
        idle();
    endtask

    task automatic test_signed_unsigned();
        push(mk_meta(32'h500, 1'b1, 32'h540));
        step(1'b0, NO_META, mk_br(32'h500, 3'd4, 32'h40, 32'hFFFF_FFFF, 32'd1));
        n_cmp++;
        if ({branch_taken_ex, mispredict} !== 2'b10) begin
            n_err++;
            $display("FAIL blt: got t=%b mis=%b expected 1 0", branch_taken_ex, mispredict);
        end
        push(mk_meta(32'h504, 1'b1, 32'h544));
        step(1'b0, NO_META, mk_br(32'h504, 3'd6, 32'h40, 32'hFFFF_FFFF, 32'd1));
        n_cmp++;
        if ({branch_taken_ex, mispredict, redirect_pc} !== {2'b01, 32'h508}) begin
            n_err++;
            $display("FAIL bltu: got t=%b mis=%b redir=%h expected 0 1 508",
                     branch_taken_ex, mispredict, redirect_pc);
        end
        idle();
    endtask

    task automatic test_all_conditions();
        logic [31:0] vals [4];
        vals[0] = 32'h0; vals[1] = 32'h1; vals[2] = 32'hFFFF_FFFF; vals[3] = 32'h8000_0000;
        for (int i = 0; i < 16; i++) begin
            logic [31:0] pc;
            pc = 32'hB00 + 32'(i) * 32'h10;
            push(mk_meta(pc, 1'($urandom_range(0, 1)), pc + 32'h40));
            step(1'b0, NO_META, mk_br(pc, 3'(i % 8), 32'h40,
                                      vals[$urandom_range(0, 3)], vals[$urandom_range(0, 3)]));
            idle();
        end
        n_cmp++;
        if ({branch_cnt, mispredict_cnt} !== {m_bcnt, m_mcnt}) begin
            n_err++;
            $display("FAIL cond_counters: got %0d/%0d expected %0d/%0d",
                     branch_cnt, mispredict_cnt, m_bcnt, m_mcnt);
        end
    endtask

    task automatic test_alias_and_mismatch();
        push(mk_meta(32'h600, 1'b1, 32'h700));
        step(1'b0, NO_META, mk_alu(32'h600));
        n_cmp++;
        if ({branch_ex, mispredict, redirect_pc, branch_cnt} !== {2'b01, 32'h604, m_bcnt}) begin
            n_err++;
            $display("FAIL alias: got br=%b mis=%b redir=%h bcnt=%0d expected 0 1 604 %0d",
                     branch_ex, mispredict, redirect_pc, branch_cnt, m_bcnt);
        end
        idle();
        push(mk_meta(32'h700, 1'b1, 32'h780));
        step(1'b0, NO_META, mk_br(32'h704, 3'd0, 32'h10, 32'd1, 32'd2));
        n_cmp++;
        if (mispredict !== 1'b0) begin
            n_err++;
            $display("FAIL pc_mismatch: got mis=%b expected 0", mispredict);
        end
        step(1'b0, NO_META, mk_alu(32'h700));
        idle();
    endtask

    task automatic test_back_to_back();
        push(mk_meta(32'h800, 1'b0, 32'h0));
        push(mk_meta(32'h804, 1'b1, 32'h900));
        step(1'b0, NO_META, mk_br(32'h800, 3'd0, 32'h10, 32'd7, 32'd7));
        // flush cycle: EX still resolves against the head, the push is dropped
        step(1'b1, mk_meta(32'h808, 1'b1, 32'h999),
             mk_br(32'h804, 3'd1, 32'hFC, 32'd1, 32'd2));
        n_cmp++;
        if ({branch_ex, mispredict, branch_target_pc} !== {2'b10, 32'h900}) begin
            n_err++;
            $display("FAIL b2b_eval: got br=%b mis=%b tgt=%h expected 1 0 900",
                     branch_ex, mispredict, branch_target_pc);
        end
        step(1'b0, NO_META, mk_br(32'h808, 3'd0, 32'h10, 32'd1, 32'd2));
        idle();
    endtask

    task automatic test_reset_mid();
        push(mk_meta(32'hA00, 1'b0, 32'h0));
        push(mk_meta(32'hA04, 1'b1, 32'hA80));
        push(mk_meta(32'hA08, 1'b1, 32'hA80));
        push(mk_meta(32'hA0C, 1'b1, 32'hA80));
        step(1'b0, NO_META, mk_jalr(32'hA00, 32'h0, 32'h2001));
        #2;
        cpu_rst = 1'b1;
        model_reset();
        #1;
        n_cmp++;
        if ({branch_ex, jalr_ex, branch_pc_ex, branch_target_pc, branch_taken_ex,
             predict1_taken_ex, predict3_taken_ex, is_loop_ex, src_data1_ex,
             src_data2_ex, mispredict, redirect_pc, branch_cnt, mispredict_cnt,
             fetch_ready} !== {230'd0, 1'b1}) begin
            n_err++;
            $display("FAIL async_reset: got br=%b mis=%b redir=%h cnt=%h/%h rdy=%b expected zeros rdy=1",
                     branch_ex, mispredict, redirect_pc, branch_cnt, mispredict_cnt, fetch_ready);
        end
        #3;
        cpu_rst = 1'b0;
        // 0xA04 was queued predicted-taken; an emptied FIFO means no mispredict
        step(1'b0, NO_META, mk_br(32'hA04, 3'd0, 32'h10, 32'd1, 32'd2));
        idle();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_beq_mispredict();
        test_bne_correct();
        test_jalr();
        test_fifo_full_flush();
        test_signed_unsigned();
        test_all_conditions();
        test_alias_and_mismatch();
        test_back_to_back();
        test_reset_mid();
        n_cmp++;
        if ({branch_cnt, mispredict_cnt} !== {m_bcnt, m_mcnt}) begin
            n_err++;
            $display("FAIL final_counters: got %0d/%0d expected %0d/%0d",
                     branch_cnt, mispredict_cnt, m_bcnt, m_mcnt);
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL missing_outputs: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Resolves conditional branches and JALR in EX, and closes the loop with the fetch-side branch predictor.
- Holds per-fetch prediction metadata in a small in-flight FIFO and pops it when the matching instruction reaches EX.
- Computes the actual outcome and target, and raises mispredict with a redirect PC.
- Drives the predictor's update interface (branch_ex, branch_taken_ex, predict1/3_taken_ex, is_loop_ex, ...) one cycle after EX, and keeps saturating branch/mispredict statistics.

Parameters:
- ADDR_WIDTH, 32, PC / target width (matches `ADDR_WIDTH)
- DATA_WIDTH, 32, operand width (matches `DATA_WIDTH)
- FIFO_DEPTH, 4, in-flight prediction entries; power of 2, at least 2
- CNT_WIDTH, 32, statistics counter width

Ports:
- cpu_clk  in  1  core clock
- cpu_rst  in  1  asynchronous, active-high reset
- fetch_valid  in  1  fetch issues an instruction with prediction metadata
- fetch_ready  out  1  FIFO not full; a push occurs when fetch_valid && fetch_ready
- fetch_pc  in  ADDR_WIDTH  fetched PC
- predict_taken  in  1  selected prediction
- predict1_taken  in  1  predictor-1 opinion
- predict3_taken  in  1  predictor-3 opinion
- is_loop  in  1  loop detector flag
- predict_target_pc  in  ADDR_WIDTH  predicted target
- ex_valid  in  1  instruction present in EX; pops the FIFO head
- ex_pc  in  ADDR_WIDTH  EX PC
- ex_is_branch  in  1  conditional branch
- ex_is_jalr  in  1  JALR
- ex_funct3  in  3  branch condition
- ex_imm  in  DATA_WIDTH  sign-extended offset
- src_data1  in  DATA_WIDTH  rs1 value
- src_data2  in  DATA_WIDTH  rs2 value
- branch_ex  out  1  registered update strobe (branch or jalr)
- jalr_ex  out  1  registered
- branch_pc_ex  out  ADDR_WIDTH  registered ex_pc
- branch_target_pc  out  ADDR_WIDTH  registered actual target
- branch_taken_ex  out  1  registered actual outcome
- predict1_taken_ex  out  1  registered head.predict1
- predict3_taken_ex  out  1  registered head.predict3
- is_loop_ex  out  1  registered head.is_loop
- src_data1_ex  out  DATA_WIDTH  registered operand
- src_data2_ex  out  DATA_WIDTH  registered operand
- mispredict  out  1  registered one-cycle flush pulse
- redirect_pc  out  ADDR_WIDTH  correct next PC, valid with mispredict
- branch_cnt  out  CNT_WIDTH  resolved branches/jalr
- mispredict_cnt  out  CNT_WIDTH  mispredictions

Behaviour:
- Reset: all outputs are 0, FIFO is empty, fetch_ready is 1, and both counters are 0.
- FIFO: circular with ptr+1-bit wrap flag; full when pointers are equal and flags differ; fetch_ready = !full.
- Pop/push ordering: a pop on ex_valid frees a slot the same cycle, but fetch_ready does not see it (no combinational path from ex_valid).
- Head match: head matches when not empty and head.pc == ex_pc.
  - On no match, or when empty, use predicted = 0, predict1 = predict3 = is_loop = 0.
  - ex_valid on an empty FIFO does not move the pointers.
- Conditional branch outcome by funct3:
  - 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge.
  - Any other funct3: taken = 0.
- Targets:
  - Conditional branch target = ex_pc + ex_imm, truncated to ADDR_WIDTH.
  - JALR: taken = 1, target = (src_data1 + ex_imm) & ~1.
- Mispredict conditions (otherwise none):
  - Branch/jalr: predicted != taken, or both taken and predict_target_pc != target.
  - Non-control instruction whose head.predicted = 1 (BTB alias): mispredict, no predictor update.
- redirect_pc = taken ? target : ex_pc + 4.
- Latency: all update, redirect and mispredict outputs are registered, one cycle after the EX cycle.
- branch_ex is a single-cycle pulse; payload outputs hold their last value when branch_ex = 0.
- Flush: the cycle mispredict is registered, the FIFO empties (rd_ptr := wr_ptr, after this cycle's pop), because younger entries are wrong-path.
  - A fetch push in that same cycle is dropped.
  - mispredict and a new ex_valid in the same cycle: the EX instruction is still evaluated normally.
- Counters:
  - branch_cnt increments on each branch_ex.
  - mispredict_cnt increments on each mispredict.
  - Both saturate at all-ones.
- Reset mid-operation: asynchronous clear to the reset state; in-flight entries are lost.

Decomposition:
- Shared package (e.g. core_defines.vh): funct3 branch encodings (BEQ..BGEU) and the FIFO entry field layout {pc, target, predicted, p1, p3, is_loop}.
- One sub-module, branch_meta_fifo (sync FIFO with push/pop/flush/full/empty).
- Compare and target logic stays in the top module.

Test Plan:
- Push pc=0x100 pred=0; EX beq with src1=src2=5, imm=0x20 -> next cycle branch_ex=1, taken=1, mispredict=1, redirect_pc=0x120, mispredict_cnt=1.
- Push pc=0x200 pred=1 tgt=0x1F0; EX bne src1=1, src2=2, imm=-0x10 -> taken=1, mispredict=0, branch_cnt increments.
- JALR at 0x300, src1=0x1003, imm=0 with pred tgt=0x1002 -> target=0x1002, no mispredict; with pred tgt=0x1000 -> mispredict, redirect_pc=0x1002.
- Push 4 entries with no pop -> fetch_ready=0, 5th push ignored; one pop -> fetch_ready=1 the next cycle; a mispredict flushes -> FIFO empty, fetch_ready=1.
- blt src1=0xFFFFFFFF, src2=1 -> taken; bltu with same operands -> not taken, redirect_pc = pc+4 when pred=1.
- Assert cpu_rst mid-stream with 3 entries queued -> all outputs 0 and the FIFO empty immediately, without waiting for a clock edge.
